// File: rtl/int_mem_boot_ctrl_if.sv
// CPU instruction/data native buses and both SRAM macro ports, bundled for the boot controller.
// The controller attaches through the slave modport; the CPU/SRAM environment uses master.
interface int_mem_boot_ctrl_if #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 15
);
    logic                     i_valid;
    logic [31:0]              i_addr;
    logic [DATA_W-1:0]        i_rdata;
    logic                     i_ready;

    logic                     d_valid;
    logic [31:0]              d_addr;
    logic [DATA_W-1:0]        d_wdata;
    logic [DATA_W/8-1:0]      d_wstrb;
    logic [DATA_W-1:0]        d_rdata;
    logic                     d_ready;

    logic                     sram_i_en;
    logic [SRAM_ADDR_W-3:0]   sram_i_addr;
    logic [DATA_W-1:0]        sram_i_wdata;
    logic [DATA_W/8-1:0]      sram_i_wstrb;
    logic [DATA_W-1:0]        sram_i_rdata;

    logic                     sram_d_en;
    logic [SRAM_ADDR_W-3:0]   sram_d_addr;
    logic [DATA_W-1:0]        sram_d_wdata;
    logic [DATA_W/8-1:0]      sram_d_wstrb;
    logic [DATA_W-1:0]        sram_d_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_rdata, i_ready,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ready,
        output sram_i_en, sram_i_addr, sram_i_wdata, sram_i_wstrb,
        input  sram_i_rdata,
        output sram_d_en, sram_d_addr, sram_d_wdata, sram_d_wstrb,
        input  sram_d_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_rdata, i_ready,
        output d_valid, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ready,
        input  sram_i_en, sram_i_addr, sram_i_wdata, sram_i_wstrb,
        output sram_i_rdata,
        input  sram_d_en, sram_d_addr, sram_d_wdata, sram_d_wstrb,
        output sram_d_rdata
    );
endinterface

// File: rtl/int_mem_boot_ctrl.sv
// Internal-memory boot controller: boot FSM with timed CPU resets, firmware load port, boot remap.
// Optional checksum of loaded firmware is enabled by defining INT_MEM_BOOT_CSUM_EN.
module int_mem_boot_ctrl #(
    parameter int DATA_W         = 32,
    parameter int SRAM_ADDR_W    = 15,
    parameter int BOOTROM_ADDR_W = 12,
    parameter int B_BIT          = 31,
    parameter int RST_CYCLES     = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              boot_o,
    output logic              cpu_reset_o,
    int_mem_boot_ctrl_if.slave bus
);
    localparam int PTR_W  = SRAM_ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned BOOT_OFFSET = (1 << PTR_W) - (1 << (BOOTROM_ADDR_W - 2));
    localparam logic [PTR_W-1:0] BOOT_OFFSET_W = PTR_W'(BOOT_OFFSET);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PRE,
        ST_BOOT,
        ST_HOLD,
        ST_RUN
    } bootState_e;

    bootState_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  loadPtr_q, loadPtr_d;
    logic              ovf_q, ovf_d;
    logic              iReady_q;
    logic              dReady_q;
    logic              dSramResp_q;
    logic [DATA_W-1:0] regRdata_q, regRdata_d;

    logic              bootActive;
    logic              regAccess;
    logic              regWrite;
    logic              selLoad;
    logic              selCtrl;
    logic              loadWrite;
    logic              loadDrop;
    logic              loadIssue;
    logic              endBoot;
    logic              iIssue;
    logic [PTR_W-1:0]  addrOffset;
    logic [PTR_W-1:0]  iWord;
    logic [PTR_W-1:0]  dWord;
    logic              unused_addrBits;

    // Boot sequencing: reset pulse, bootloader run, second reset pulse, then normal operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_PRE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bootActive  = 1'b0;
        cpu_reset_o = 1'b0;
        unique case (state_q)
            ST_PRE: begin
                bootActive  = 1'b1;
                cpu_reset_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_BOOT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BOOT: begin
                bootActive = 1'b1;
                if (endBoot) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                cpu_reset_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_PRE;
                cnt_d   = '0;
            end
        endcase
    end

    assign boot_o = bootActive;

    // Register writes only take effect while the bootloader owns the machine.
    assign regAccess = bus.d_valid & bus.d_addr[B_BIT];
    assign regWrite  = regAccess & (bus.d_wstrb != '0) & (state_q == ST_BOOT);

`ifdef INT_MEM_BOOT_CSUM_EN
    logic              selCsum;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] csumMasked;

    assign selCsum = (bus.d_addr[3:2] == 2'd2);
    assign selLoad = ~bus.d_addr[2] & ~selCsum;
    assign selCtrl = bus.d_addr[2];
`else
    assign selLoad = ~bus.d_addr[2];
    assign selCtrl = bus.d_addr[2];
`endif

    assign loadWrite = regWrite & selLoad;
    assign loadDrop  = loadWrite & (loadPtr_q == BOOT_OFFSET_W);
    assign loadIssue = loadWrite & ~loadDrop;
    assign endBoot   = regWrite & selCtrl & bus.d_wdata[0];
    assign iIssue    = bus.i_valid & ~loadIssue;

    // Bootloader lives in the top of SRAM; the modulo wrap comes from the word-address width.
    assign addrOffset = bootActive ? BOOT_OFFSET_W : '0;
    assign iWord      = bus.i_addr[SRAM_ADDR_W-1:2] + addrOffset;
    assign dWord      = bus.d_addr[SRAM_ADDR_W-1:2] + addrOffset;

    always_comb begin
        bus.sram_i_en    = 1'b0;
        bus.sram_i_addr  = iWord;
        bus.sram_i_wdata = '0;
        bus.sram_i_wstrb = '0;
        if (loadIssue) begin
            bus.sram_i_en    = 1'b1;
            bus.sram_i_addr  = loadPtr_q;
            bus.sram_i_wdata = bus.d_wdata;
            bus.sram_i_wstrb = bus.d_wstrb;
        end else if (bus.i_valid) begin
            bus.sram_i_en = 1'b1;
        end
    end

    assign bus.sram_d_en    = bus.d_valid & ~bus.d_addr[B_BIT];
    assign bus.sram_d_addr  = dWord;
    assign bus.sram_d_wdata = bus.d_wdata;
    assign bus.sram_d_wstrb = bus.d_wstrb;

    // Load pointer stops at the bootloader boundary; a dropped write flags overflow.
    always_comb begin
        loadPtr_d = loadPtr_q;
        ovf_d     = ovf_q | loadDrop;
        if (loadIssue) begin
            loadPtr_d = loadPtr_q + PTR_W'(1);
        end
    end

    always_comb begin
        regRdata_d = DATA_W'({ovf_q, bootActive, loadPtr_q});
        if (selLoad) begin
            regRdata_d = DATA_W'(loadPtr_q);
        end
`ifdef INT_MEM_BOOT_CSUM_EN
        if (selCsum) begin
            regRdata_d = csum_q;
        end
`endif
    end

`ifdef INT_MEM_BOOT_CSUM_EN
    always_comb begin
        csumMasked = '0;
        for (int b = 0; b < STRB_W; b++) begin
            if (bus.d_wstrb[b]) begin
                csumMasked[8*b +: 8] = bus.d_wdata[8*b +: 8];
            end
        end
        csum_d = loadIssue ? (csum_q + csumMasked) : csum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Every accepted request answers exactly one cycle later; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadPtr_q   <= '0;
            ovf_q       <= 1'b0;
            iReady_q    <= 1'b0;
            dReady_q    <= 1'b0;
            dSramResp_q <= 1'b0;
            regRdata_q  <= '0;
        end else begin
            loadPtr_q   <= loadPtr_d;
            ovf_q       <= ovf_d;
            iReady_q    <= iIssue;
            dReady_q    <= bus.d_valid;
            dSramResp_q <= ~bus.d_addr[B_BIT];
            regRdata_q  <= regRdata_d;
        end
    end

    assign bus.i_rdata = bus.sram_i_rdata;
    assign bus.i_ready = iReady_q;
    assign bus.d_ready = dReady_q;
    assign bus.d_rdata = !dReady_q  ? '0 :
                         dSramResp_q ? bus.sram_d_rdata : regRdata_q;

    assign unused_addrBits = ^{bus.i_addr, bus.d_addr};

endmodule

// File: tb/tb_int_mem_boot_ctrl.sv
// Self-checking bench for int_mem_boot_ctrl: scoreboarded responses against a small SRAM model.
module tb_int_mem_boot_ctrl;
    localparam int          WORDS       = 8192;
    localparam int          BOOT_OFFSET = 32'h1C00;
    localparam logic [31:0] LOAD_ADDR   = 32'h8000_0000;
    localparam logic [31:0] CTRL_ADDR   = 32'h8000_0004;
    localparam logic [31:0] AUX_ADDR    = 32'h8000_0008;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        chk;
    } resp_t;

    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bootO;
    logic cpuResetO;

    int vectorCount = 0;
    int missCount   = 0;
    int cyc         = 0;

    int          ptrModel  = 0;
    logic        ovfModel  = 1'b0;
    logic        bootModel = 1'b1;
    logic [31:0] csumModel = '0;

    logic [31:0] mem [0:WORDS-1];
    resp_t       iExpQ[$];
    resp_t       dExpQ[$];
    wr_t         wrExpQ[$];
    resp_t       iResp;
    resp_t       dResp;
    wr_t         wrNow;

    int_mem_boot_ctrl_if #(.DATA_W(32), .SRAM_ADDR_W(15)) ifc ();

    int_mem_boot_ctrl #(
        .DATA_W(32),
        .SRAM_ADDR_W(15),
        .BOOTROM_ADDR_W(12),
        .B_BIT(31),
        .RST_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_o     (bootO),
        .cpu_reset_o(cpuResetO),
        .bus        (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port SRAM model with one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        logic [31:0] tmp;
        if (ifc.sram_i_en) begin
            ifc.sram_i_rdata <= mem[ifc.sram_i_addr];
            tmp = mem[ifc.sram_i_addr];
            for (int b = 0; b < 4; b++) begin
                if (ifc.sram_i_wstrb[b]) tmp[8*b +: 8] = ifc.sram_i_wdata[8*b +: 8];
            end
            mem[ifc.sram_i_addr] <= tmp;
        end
        if (ifc.sram_d_en) begin
            ifc.sram_d_rdata <= mem[ifc.sram_d_addr];
            tmp = mem[ifc.sram_d_addr];
            for (int b = 0; b < 4; b++) begin
                if (ifc.sram_d_wstrb[b]) tmp[8*b +: 8] = ifc.sram_d_wdata[8*b +: 8];
            end
            mem[ifc.sram_d_addr] <= tmp;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] maskData(input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
        end
        return m;
    endfunction

    function automatic logic [31:0] ctrlExpect();
        return (32'(ovfModel) << 14) | (32'(bootModel) << 13) | 32'(ptrModel);
    endfunction

    // Response and port-A write scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.i_ready) begin
                if (iExpQ.size() == 0) begin
                    checkOutput("iReadyUnexpected", 64'(ifc.i_ready), 64'd0);
                end else begin
                    iResp = iExpQ.pop_front();
                    checkOutput("iReadyCycle", 64'(cyc), 64'(iResp.due));
                    checkOutput("iRdata", 64'(ifc.i_rdata), 64'(iResp.data));
                end
            end
            if (ifc.d_ready) begin
                if (dExpQ.size() == 0) begin
                    checkOutput("dReadyUnexpected", 64'(ifc.d_ready), 64'd0);
                end else begin
                    dResp = dExpQ.pop_front();
                    checkOutput("dReadyCycle", 64'(cyc), 64'(dResp.due));
                    if (dResp.chk) checkOutput("dRdata", 64'(ifc.d_rdata), 64'(dResp.data));
                end
            end
            if (ifc.sram_i_en && ifc.sram_i_wstrb != '0) begin
                if (wrExpQ.size() == 0) begin
                    checkOutput("portAWriteUnexpected", 64'(ifc.sram_i_addr), 64'h1_0000);
                end else begin
                    wrNow = wrExpQ.pop_front();
                    checkOutput("portAWriteAddr", 64'(ifc.sram_i_addr), 64'(wrNow.addr));
                    checkOutput("portAWriteData", 64'(ifc.sram_i_wdata), 64'(wrNow.data));
                    checkOutput("portAWriteStrb", 64'(ifc.sram_i_wstrb), 64'(wrNow.strb));
                end
            end
        end
    end

    // One data-bus request held for a single cycle; optionally checks the port-B word address.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic chkData, input logic [31:0] expData,
                                 input logic chkWord, input logic [12:0] expWord);
        resp_t r;
        ifc.d_valid = 1'b1;
        ifc.d_addr  = addr;
        ifc.d_wdata = wdata;
        ifc.d_wstrb = strb;
        r.due  = cyc + 1;
        r.data = expData;
        r.chk  = chkData;
        dExpQ.push_back(r);
        @(negedge clk);
        if (chkWord) begin
            checkOutput("dSramAddr", 64'(ifc.sram_d_addr), 64'(expWord));
            checkOutput("dSramEn", 64'(ifc.sram_d_en), 64'd1);
        end
        @(posedge clk);
        #1;
        ifc.d_valid = 1'b0;
        ifc.d_wstrb = '0;
    endtask

    task automatic loadWrite(input logic [31:0] data, input logic [3:0] strb);
        wr_t w;
        if (bootModel) begin
            if (ptrModel < BOOT_OFFSET) begin
                w.addr = 13'(ptrModel);
                w.data = data;
                w.strb = strb;
                wrExpQ.push_back(w);
                ptrModel++;
                csumModel += maskData(data, strb);
            end else begin
                ovfModel = 1'b1;
            end
        end
        applyStimulus(LOAD_ADDR, data, strb, 1'b0, 32'h0, 1'b0, 13'h0);
    endtask

    task automatic iRead(input logic [31:0] addr, input logic [12:0] expWord);
        resp_t r;
        ifc.i_valid = 1'b1;
        ifc.i_addr  = addr;
        r.due  = cyc + 1;
        r.data = mem[expWord];
        r.chk  = 1'b1;
        iExpQ.push_back(r);
        @(negedge clk);
        checkOutput("iSramAddr", 64'(ifc.sram_i_addr), 64'(expWord));
        checkOutput("iSramEn", 64'(ifc.sram_i_en), 64'd1);
        @(posedge clk);
        #1;
        ifc.i_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resp_t r;
        wr_t   w;
        for (int k = 0; k < WORDS; k++) mem[k] = 32'hA500_0000 | 32'(k);
        ifc.i_valid      = 1'b0;
        ifc.i_addr       = '0;
        ifc.d_valid      = 1'b0;
        ifc.d_addr       = '0;
        ifc.d_wdata      = '0;
        ifc.d_wstrb      = '0;
        ifc.sram_i_rdata = '0;
        ifc.sram_d_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstBoot", 64'(bootO), 64'd1);
        checkOutput("rstCpuReset", 64'(cpuResetO), 64'd1);
        checkOutput("rstIReady", 64'(ifc.i_ready), 64'd0);
        checkOutput("rstDReady", 64'(ifc.d_ready), 64'd0);
        checkOutput("rstDRdata", 64'(ifc.d_rdata), 64'd0);

        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("preCpuReset", 64'(cpuResetO), 64'd1);
        end
        @(negedge clk);
        checkOutput("bootCpuReset", 64'(cpuResetO), 64'd0);
        checkOutput("bootFlag", 64'(bootO), 64'd1);
        step();

        iRead(32'h0, 13'h1C00);

        loadWrite(32'h11, 4'hF);
        loadWrite(32'h22, 4'hF);
        loadWrite(32'h33, 4'hF);
        applyStimulus(CTRL_ADDR, 32'h0, 4'h0, 1'b1, ctrlExpect(), 1'b0, 13'h0);

        // LOAD write and instruction fetch contend for port A in the same cycle.
        w.addr = 13'(ptrModel);
        w.data = 32'hAABB_CC44;
        w.strb = 4'b0101;
        wrExpQ.push_back(w);
        ptrModel++;
        csumModel += maskData(32'hAABB_CC44, 4'b0101);
        r.due = cyc + 1; r.data = 32'h0; r.chk = 1'b0;
        dExpQ.push_back(r);
        r.due = cyc + 2; r.data = mem[13'h1C02]; r.chk = 1'b1;
        iExpQ.push_back(r);
        ifc.d_valid = 1'b1;
        ifc.d_addr  = LOAD_ADDR;
        ifc.d_wdata = 32'hAABB_CC44;
        ifc.d_wstrb = 4'b0101;
        ifc.i_valid = 1'b1;
        ifc.i_addr  = 32'h8;
        @(negedge clk);
        checkOutput("arbWriteFirst", 64'(ifc.sram_i_wstrb), 64'h5);
        step();
        ifc.d_valid = 1'b0;
        ifc.d_wstrb = '0;
        @(negedge clk);
        checkOutput("arbReadAddr", 64'(ifc.sram_i_addr), 64'h1C02);
        checkOutput("arbReadStrb", 64'(ifc.sram_i_wstrb), 64'h0);
        step();
        ifc.i_valid = 1'b0;

        applyStimulus(LOAD_ADDR, 32'h0, 4'h0, 1'b1, 32'(ptrModel), 1'b0, 13'h0);
        applyStimulus(32'h0000_0010, 32'h0, 4'h0, 1'b1, mem[13'h1C04], 1'b1, 13'h1C04);
`ifdef INT_MEM_BOOT_CSUM_EN
        applyStimulus(AUX_ADDR, 32'h0, 4'h0, 1'b1, csumModel, 1'b0, 13'h0);
`else
        applyStimulus(AUX_ADDR, 32'h0, 4'h0, 1'b1, 32'(ptrModel), 1'b0, 13'h0);
`endif

        while (ptrModel < BOOT_OFFSET) loadWrite(32'h1000_0000 + 32'(ptrModel), 4'hF);
        loadWrite(32'hDEAD_BEEF, 4'hF);
        applyStimulus(CTRL_ADDR, 32'h0, 4'h0, 1'b1, ctrlExpect(), 1'b0, 13'h0);
`ifdef INT_MEM_BOOT_CSUM_EN
        applyStimulus(AUX_ADDR, 32'h0, 4'h0, 1'b1, csumModel, 1'b0, 13'h0);
`endif

        applyStimulus(CTRL_ADDR, 32'h1, 4'hF, 1'b0, 32'h0, 1'b0, 13'h0);
        bootModel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("holdCpuReset", 64'(cpuResetO), 64'd1);
            checkOutput("holdBoot", 64'(bootO), 64'd0);
        end
        @(negedge clk);
        checkOutput("runCpuReset", 64'(cpuResetO), 64'd0);
        step();

        iRead(32'h0, 13'h0);
        applyStimulus(32'h0000_0020, 32'h0, 4'h0, 1'b1, mem[13'h8], 1'b1, 13'h8);
        loadWrite(32'h5555_5555, 4'hF);
        applyStimulus(CTRL_ADDR, 32'h1, 4'hF, 1'b0, 32'h0, 1'b0, 13'h0);
        applyStimulus(CTRL_ADDR, 32'h0, 4'h0, 1'b1, ctrlExpect(), 1'b0, 13'h0);

        repeat (3) step();
        checkOutput("iQueueDrained", 64'(iExpQ.size()), 64'd0);
        checkOutput("dQueueDrained", 64'(dExpQ.size()), 64'd0);
        checkOutput("wrQueueDrained", 64'(wrExpQ.size()), 64'd0);

        // Reset lands while an instruction response is outstanding.
        ifc.i_valid = 1'b1;
        ifc.i_addr  = 32'h4;
        step();
        ifc.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstIReady", 64'(ifc.i_ready), 64'd0);
        checkOutput("midRstBoot", 64'(bootO), 64'd1);
        checkOutput("midRstCpuReset", 64'(cpuResetO), 64'd1);
        checkOutput("midRstDRdata", 64'(ifc.d_rdata), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
